countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
- Parametrised successor of the team's button-driven countdown timer.
- BCD countdown (mm:ss or hh:mm:ss) with a four-state controller: counting, paused, set-up, finished.
- On-chip button conditioning and per-digit editing.
- Feeds the VGA digit renderer with BCD time, state and the edit-cursor position.

Parameters:
- NUM_DIGITS, 4, BCD digit count; legal values are 4 (mm:ss) and 6 (hh:mm:ss).
- TICK_CYCLES, 50_000_000, clk cycles per one-second decrement.
- DEBOUNCE_CYCLES, 500_000, cycles a synchronised button must stay stable before it is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- up_btn  in  1  raw button, asynchronous; increments the selected digit.
- down_btn  in  1  raw button; decrements the selected digit.
- left_btn  in  1  raw button; cursor left; in PAUSED, enter SETUP.
- right_btn  in  1  raw button; cursor right.
- action_btn  in  1  raw button; start / pause / resume / acknowledge.
- time_bcd  out  4*NUM_DIGITS  displayed time, digit 0 = seconds units at the LSBs.
- state  out  2  0 COUNTING, 1 PAUSED, 2 SETUP, 3 FINISHED.
- sel_digit  out  3  edit-cursor index, 0..NUM_DIGITS-1.
- expired  out  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (async assert, sync-released internally): state=SETUP, time_bcd=0, preset=0, sel_digit=0, expired=0, prescaler=0.
- Button path:
  - 2-FF synchroniser, then debounce counter, then rising-edge detector.
  - Each press yields exactly one 1-cycle pulse.
  - Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Digit limits:
  - Even-index digits: 0..9.
  - Odd-index digits 1 and 3: 0..5.
  - Digit 5: 0..9.
- Same-cycle pulse priority: action > left/right > up/down. Lower-priority pulses in that cycle are dropped.
- SETUP:
  - left/right move sel_digit with wrap (0 -left-> NUM_DIGITS-1).
  - up/down change the selected digit modulo its limit (9 -up-> 0, 0 -down-> 9/5). No carry into neighbouring digits.
  - action with time nonzero: latch preset<=time_bcd, clear prescaler, go to COUNTING.
  - action with time zero: ignored.
- COUNTING:
  - Prescaler counts 0..TICK_CYCLES-1. On wrap, time decrements as BCD with borrow (00:10 -> 00:09; 01:00 -> 00:59).
  - The first decrement occurs exactly TICK_CYCLES cycles after entry.
  - Decrement that yields zero: same edge sets state=FINISHED and pulses expired.
  - action: go to PAUSED, prescaler frozen (not cleared).
- PAUSED:
  - action resumes COUNTING with the prescaler continuing from its frozen value.
  - left goes to SETUP keeping the current time and setting sel_digit=0.
  - up, down and right are ignored.
- FINISHED:
  - time holds zero.
  - action: time_bcd<=preset, state=SETUP.
  - Other buttons are ignored.
- Reset asserted mid-count: immediate return to reset values; preset is lost.
- No decrement is possible below zero. An all-zero time is never in COUNTING.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined: on reaching zero, expired pulses, time_bcd<=preset on the same edge, and the state stays COUNTING. FINISHED is unreachable.
- Undefined: behaviour as above.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_COUNTING=0, ST_PAUSED=1, ST_SETUP=2, ST_FINISHED=3);
  - the BCD digit-limit function digit_max(index);
  - the BCD decrement-with-borrow function.
- One sub-module, button_conditioner (synchroniser + debounce + edge pulse, parameter DEBOUNCE_CYCLES), instantiated five times.

Test Plan (all with TICK_CYCLES=10, DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Reset, then set 00:03 via up×3 and press action -> state 0; time 00:02 exactly 10 cycles after the COUNTING entry, then 00:01 and 00:00; expired high for exactly 1 cycle; state 3.
- Preset 01:00 and count one tick -> time 00:59 (borrow across digits 0, 1 and 2).
- Count, then action at a mid-prescaler value of 6 -> state 1, time frozen; after a second action, the next decrement arrives 4 cycles later.
- SETUP with sel=0: left -> sel=3; up×6 on digit 3 -> digit goes 0..5 then 0. down on digit 0 from 0 -> 9.
- Same-cycle action and up pulses in SETUP with nonzero time -> COUNTING; the digit is unchanged.
- FINISHED, then action -> state 2 and time equals the last preset. With COUNTDOWN_TIMER_AUTORELOAD_EN, the expiry instead reloads the preset and state stays 0. Reset asserted mid-count -> outputs immediately return to reset values.

Source files
------------

// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and BCD helpers for the countdown timer controller.
// Latency: combinational helpers only.
// Backpressure: none.
package countdown_timer_ctrl_pkg;

    localparam int MAX_DIGITS = 6;
    localparam int MAX_W      = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {
        ST_COUNTING = 2'd0,
        ST_PAUSED   = 2'd1,
        ST_SETUP    = 2'd2,
        ST_FINISHED = 2'd3
    } state_e;

    // Odd digits 1 and 3 are tens of seconds/minutes; everything else counts to 9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 1 || idx == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [MAX_W-1:0] bcd_dec(input logic [MAX_W-1:0] t, input int n_digits);
        logic [MAX_W-1:0] r;
        logic             borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n_digits && borrow) begin
                if (t[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_button_conditioner.sv
// Raw button to single-cycle press pulse: 2-FF sync, debounce, rising-edge detect.
// Latency: 2 + DEBOUNCE_CYCLES + 1 cycles from press to pulse.
// Backpressure: none; the button is sampled every cycle.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // Accept a new level only after it differed for DEBOUNCE_CYCLES consecutive cycles.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Button-driven BCD countdown timer with SETUP/COUNTING/PAUSED/FINISHED control; COUNTDOWN_TIMER_AUTORELOAD_EN reloads the preset on expiry.
// Latency: state/time update one cycle after a conditioned button pulse; one decrement per TICK_CYCLES.
// Backpressure: none; outputs are free-running registers.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    up_btn,
    input  logic                    down_btn,
    input  logic                    left_btn,
    input  logic                    right_btn,
    input  logic                    action_btn,
    output logic [4*NUM_DIGITS-1:0] time_bcd,
    output logic [1:0]              state,
    output logic [2:0]              sel_digit,
    output logic                    expired
);

    localparam int TW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_CYCLES + 1);

    // Asynchronous assert, synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic [4:0] raw_btn, pulse;
    assign raw_btn = {action_btn, left_btn, right_btn, up_btn, down_btn};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
            .clk    (clk),
            .rst_n  (rst_int_n),
            .btn_i  (raw_btn[g]),
            .pulse_o(pulse[g])
        );
    end

    logic act_p, lft_p, rgt_p, up_p, dn_p;
    assign {act_p, lft_p, rgt_p, up_p, dn_p} = pulse;

    state_e          state_q, state_d;
    logic [TW-1:0]   time_q, time_d;
    logic [TW-1:0]   preset_q, preset_d;
    logic [2:0]      sel_q, sel_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            expired_q, expired_d;

    logic [MAX_W-1:0] dec_full;
    logic             dec_zero;
    logic             tick;

    assign dec_full = bcd_dec(MAX_W'(time_q), NUM_DIGITS);
    assign dec_zero = (dec_full == '0);
    assign tick     = (presc_q == PW'(TICK_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        preset_d  = preset_q;
        sel_d     = sel_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        case (state_q)
            ST_SETUP: begin
                // One action per cycle: action beats cursor moves, which beat digit edits.
                if (act_p) begin
                    if (time_q != '0) begin
                        preset_d = time_q;
                        presc_d  = '0;
                        state_d  = ST_COUNTING;
                    end
                end else if (lft_p) begin
                    sel_d = (sel_q == 3'd0) ? 3'(NUM_DIGITS - 1) : sel_q - 3'd1;
                end else if (rgt_p) begin
                    sel_d = (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
                end else if (up_p || dn_p) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (sel_q == 3'(i)) begin
                            if (up_p)
                                time_d[4*i +: 4] = (time_q[4*i +: 4] == digit_max(i)) ?
                                                   4'd0 : time_q[4*i +: 4] + 4'd1;
                            else
                                time_d[4*i +: 4] = (time_q[4*i +: 4] == 4'd0) ?
                                                   digit_max(i) : time_q[4*i +: 4] - 4'd1;
                        end
                    end
                end
            end
            ST_COUNTING: begin
                if (act_p) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    if (dec_zero) begin
                        expired_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        time_d    = preset_q;
`else
                        time_d    = '0;
                        state_d   = ST_FINISHED;
`endif
                    end else begin
                        time_d = dec_full[TW-1:0];
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSED: begin
                if (act_p) begin
                    state_d = ST_COUNTING;
                end else if (lft_p) begin
                    state_d = ST_SETUP;
                    sel_d   = 3'd0;
                end
            end
            ST_FINISHED: begin
                if (act_p) begin
                    time_d  = preset_q;
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_SETUP;
            time_q    <= '0;
            preset_q  <= '0;
            sel_q     <= 3'd0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            preset_q  <= preset_d;
            sel_q     <= sel_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    assign time_bcd  = time_q;
    assign state     = state_q;
    assign sel_digit = sel_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl with small tick/debounce constants.
module tb_countdown_timer_ctrl;

    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int ND   = 4;

    localparam logic [1:0] S_CNT = 2'd0, S_PAU = 2'd1, S_SET = 2'd2, S_FIN = 2'd3;
    localparam logic [4:0] B_DN = 5'b00001, B_UP = 5'b00010, B_RT = 5'b00100,
                           B_LT = 5'b01000, B_ACT = 5'b10000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic up_btn = 1'b0, down_btn = 1'b0, left_btn = 1'b0, right_btn = 1'b0, action_btn = 1'b0;
    logic [4*ND-1:0] time_bcd;
    logic [1:0]      state;
    logic [2:0]      sel_digit;
    logic            expired;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] t;
        logic [1:0]  st;
        int          gap;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    countdown_timer_ctrl #(
        .NUM_DIGITS(ND), .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_btn(up_btn), .down_btn(down_btn), .left_btn(left_btn),
        .right_btn(right_btn), .action_btn(action_btn),
        .time_bcd(time_bcd), .state(state), .sel_digit(sel_digit), .expired(expired)
    );

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input logic [4:0] m);
        {action_btn, left_btn, right_btn, up_btn, down_btn} = m;
    endtask

    task automatic press(input logic [4:0] m);
        drive(m); cyc(9); drive(5'b0); cyc(9);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc(1);
            if (state === st) found = 1'b1;
        end
    endtask

    task automatic do_reset;
        drive(5'b0);
        #2 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        cyc(3);
        checks++; if (time_bcd !== 16'h0000) begin errors++; $display("FAIL reset_time: got %h want 0000", time_bcd); end
        checks++; if (state !== S_SET) begin errors++; $display("FAIL reset_state: got %0d want 2", state); end
        checks++; if (sel_digit !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_digit); end
        checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired: got %b want 0", expired); end
        rst_n = 1'b1;
        cyc(4);
        checks++; if (state !== S_SET || time_bcd !== 16'h0000) begin errors++; $display("FAIL reset_release: got state %0d time %h want 2 0000", state, time_bcd); end
    endtask

    task automatic test_latency;
        do_reset();
        drive(B_UP);
        cyc(7);
        checks++; if (time_bcd !== 16'h0000) begin errors++; $display("FAIL latency_early: got %h want 0000", time_bcd); end
        cyc(1);
        checks++; if (time_bcd !== 16'h0001) begin errors++; $display("FAIL latency_edge: got %h want 0001", time_bcd); end
        cyc(20);
        drive(5'b0);
        cyc(10);
        checks++; if (time_bcd !== 16'h0001) begin errors++; $display("FAIL single_pulse: got %h want 0001", time_bcd); end
    endtask

    task automatic test_countdown;
        bit   found;
        int   gap, budget, nexp;
        exp_t e;
        logic [15:0] prev;
        do_reset();
        repeat (3) press(B_UP);
        checks++; if (time_bcd !== 16'h0003) begin errors++; $display("FAIL set_0003: got %h want 0003", time_bcd); end
        sb.push_back('{16'h0002, S_CNT, TICK});
        sb.push_back('{16'h0001, S_CNT, TICK});
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        sb.push_back('{16'h0003, S_CNT, TICK});
`else
        sb.push_back('{16'h0000, S_FIN, TICK});
`endif
        drive(B_ACT);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        checks++; if (!found) begin errors++; $display("FAIL start_count: got state %0d want 0", state); end
        prev = time_bcd; gap = 0; budget = 60; nexp = 0;
        while (sb.size() > 0 && budget > 0) begin
            cyc(1); budget--; gap++;
            if (expired === 1'b1) nexp++;
            if (time_bcd !== prev) begin
                e = sb.pop_front();
                checks++;
                if (time_bcd !== e.t || state !== e.st || gap != e.gap) begin
                    errors++;
                    $display("FAIL countdown_step: got time %h state %0d gap %0d want %h %0d %0d", time_bcd, state, gap, e.t, e.st, e.gap);
                end
                if (sb.size() == 0) begin
                    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL expired_edge: got %b want 1", expired); end
                end
                prev = time_bcd; gap = 0;
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL countdown_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        cyc(3);
        if (expired === 1'b1) nexp++;
        checks++; if (nexp != 1) begin errors++; $display("FAIL expired_width: got %0d cycles want 1", nexp); end
    endtask

    task automatic test_finished;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        press(B_ACT);
        checks++; if (state !== S_PAU) begin errors++; $display("FAIL reload_pause: got %0d want 1", state); end
        press(B_LT);
        checks++; if (state !== S_SET || sel_digit !== 3'd0) begin errors++; $display("FAIL reload_setup: got %0d sel %0d want 2 0", state, sel_digit); end
`else
        cyc(5);
        checks++; if (state !== S_FIN || time_bcd !== 16'h0000) begin errors++; $display("FAIL finished_hold: got %0d %h want 3 0000", state, time_bcd); end
        press(B_UP);
        checks++; if (state !== S_FIN || time_bcd !== 16'h0000) begin errors++; $display("FAIL finished_ignore: got %0d %h want 3 0000", state, time_bcd); end
        press(B_ACT);
        checks++; if (state !== S_SET || time_bcd !== 16'h0003) begin errors++; $display("FAIL finished_ack: got %0d %h want 2 0003", state, time_bcd); end
`endif
    endtask

    task automatic test_borrow;
        bit   found;
        int   gap, budget;
        exp_t e;
        logic [15:0] prev;
        do_reset();
        press(B_RT); press(B_RT);
        checks++; if (sel_digit !== 3'd2) begin errors++; $display("FAIL sel_right: got %0d want 2", sel_digit); end
        press(B_UP);
        checks++; if (time_bcd !== 16'h0100) begin errors++; $display("FAIL set_0100: got %h want 0100", time_bcd); end
        sb.push_back('{16'h0059, S_CNT, TICK});
        drive(B_ACT);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        checks++; if (!found) begin errors++; $display("FAIL borrow_start: got state %0d want 0", state); end
        prev = time_bcd; gap = 0; budget = 30;
        while (sb.size() > 0 && budget > 0) begin
            cyc(1); budget--; gap++;
            if (time_bcd !== prev) begin
                e = sb.pop_front();
                checks++;
                if (time_bcd !== e.t || state !== e.st || gap != e.gap) begin
                    errors++;
                    $display("FAIL borrow_step: got time %h state %0d gap %0d want %h %0d %0d", time_bcd, state, gap, e.t, e.st, e.gap);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL borrow_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_pause;
        bit   found;
        int   gap, budget;
        exp_t e;
        logic [15:0] prev;
        do_reset();
        repeat (5) press(B_UP);
        drive(B_ACT);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        checks++; if (!found) begin errors++; $display("FAIL pause_start: got state %0d want 0", state); end
        // Press timed so the action pulse is taken with the prescaler at 6.
        cyc(9);
        drive(B_ACT);
        wait_state(S_PAU, 20, found);
        drive(5'b0);
        checks++; if (!found || time_bcd !== 16'h0004) begin errors++; $display("FAIL pause_enter: got state %0d time %h want 1 0004", state, time_bcd); end
        cyc(15);
        checks++; if (state !== S_PAU || time_bcd !== 16'h0004) begin errors++; $display("FAIL pause_frozen: got %0d %h want 1 0004", state, time_bcd); end
        sb.push_back('{16'h0003, S_CNT, 4});
        drive(B_ACT);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        checks++; if (!found) begin errors++; $display("FAIL resume: got state %0d want 0", state); end
        prev = time_bcd; gap = 0; budget = 30;
        while (sb.size() > 0 && budget > 0) begin
            cyc(1); budget--; gap++;
            if (time_bcd !== prev) begin
                e = sb.pop_front();
                checks++;
                if (time_bcd !== e.t || state !== e.st || gap != e.gap) begin
                    errors++;
                    $display("FAIL resume_step: got time %h state %0d gap %0d want %h %0d %0d", time_bcd, state, gap, e.t, e.st, e.gap);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL resume_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_setup_edit;
        logic [3:0] want;
        do_reset();
        press(B_LT);
        checks++; if (sel_digit !== 3'd3) begin errors++; $display("FAIL left_wrap: got %0d want 3", sel_digit); end
        for (int i = 1; i <= 6; i++) begin
            press(B_UP);
            want = 4'(i % 6);
            checks++; if (time_bcd[15:12] !== want) begin errors++; $display("FAIL digit3_up: got %0d want %0d", time_bcd[15:12], want); end
        end
        press(B_RT);
        checks++; if (sel_digit !== 3'd0) begin errors++; $display("FAIL right_wrap: got %0d want 0", sel_digit); end
        press(B_DN);
        checks++; if (time_bcd !== 16'h0009) begin errors++; $display("FAIL digit0_down: got %h want 0009", time_bcd); end
    endtask

    task automatic test_priority;
        bit found;
        do_reset();
        press(B_ACT);
        checks++; if (state !== S_SET) begin errors++; $display("FAIL zero_action: got %0d want 2", state); end
        press(B_UP);
        drive(B_ACT | B_UP);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        checks++; if (!found || time_bcd !== 16'h0001) begin errors++; $display("FAIL priority: got state %0d time %h want 0 0001", state, time_bcd); end
        cyc(9);
    endtask

    task automatic test_midcount_reset;
        bit found;
        do_reset();
        press(B_RT); press(B_UP);
        drive(B_ACT);
        wait_state(S_CNT, 20, found);
        drive(5'b0);
        cyc(12);
        checks++; if (!found || time_bcd !== 16'h0009) begin errors++; $display("FAIL mid_count: got %h want 0009", time_bcd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (time_bcd !== 16'h0000 || state !== S_SET) begin errors++; $display("FAIL async_reset: got %h %0d want 0000 2", time_bcd, state); end
        checks++; if (sel_digit !== 3'd0 || expired !== 1'b0) begin errors++; $display("FAIL async_reset_sel: got %0d %b want 0 0", sel_digit, expired); end
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        press(B_ACT);
        checks++; if (state !== S_SET || time_bcd !== 16'h0000) begin errors++; $display("FAIL preset_lost: got %0d %h want 2 0000", state, time_bcd); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_countdown();
        test_finished();
        test_borrow();
        test_pause();
        test_setup_edit();
        test_priority();
        test_midcount_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
